// File: rtl/sif_pkg.sv
// sif_pkg - shared defaults for the sif_mult feeder slice.
// Holds the default operand width, the result FIFO depth (which is also the
// credit limit) and the maximum multiplier latency. It also provides a helper
// that sizes counters able to hold values 0..max inclusive.
package sif_pkg;

    localparam int SIF_WIDTH      = 32;
    localparam int SIF_FIFO_DEPTH = 16;
    localparam int SIF_MULT_LAT   = 8;

    // Bits needed to hold every value from 0 up to max_value inclusive.
    function automatic int count_width(input int max_value);
        return (max_value < 1) ? 1 : $clog2(max_value + 1);
    endfunction

    localparam int SIF_CNT_W = count_width(SIF_FIFO_DEPTH);

endpackage

// File: rtl/sif_mult_feeder_if.sv
// sif_mult_feeder_if - operand, issue and product streams of the feeder.
//   A_*      : operand A valid/ready stream (from operand fetch)
//   B_*      : operand B valid/ready stream (from operand fetch)
//   M_A/M_B_*: paired issue toward the multiplier (no ready path)
//   M_P_*    : product returning from the multiplier (no ready path)
//   P_*      : product valid/ready stream toward the accumulate stage
// master is the feeder side; slave is the surrounding environment.
interface sif_mult_feeder_if import sif_pkg::*; #(
    parameter int WIDTH = SIF_WIDTH
);

    logic             A_vld;
    logic [WIDTH-1:0] A_dat;
    logic             A_rdy;
    logic             B_vld;
    logic [WIDTH-1:0] B_dat;
    logic             B_rdy;
    logic             M_A_vld;
    logic [WIDTH-1:0] M_A_dat;
    logic             M_B_vld;
    logic [WIDTH-1:0] M_B_dat;
    logic             M_P_vld;
    logic [WIDTH-1:0] M_P_dat;
    logic             P_vld;
    logic [WIDTH-1:0] P_dat;
    logic             P_rdy;

    modport master (
        input  A_vld, A_dat, B_vld, B_dat, M_P_vld, M_P_dat, P_rdy,
        output A_rdy, B_rdy, M_A_vld, M_A_dat, M_B_vld, M_B_dat, P_vld, P_dat
    );

    modport slave (
        output A_vld, A_dat, B_vld, B_dat, M_P_vld, M_P_dat, P_rdy,
        input  A_rdy, B_rdy, M_A_vld, M_A_dat, M_B_vld, M_B_dat, P_vld, P_dat
    );

endinterface

// File: rtl/sif_fifo.sv
// sif_fifo - synchronous FIFO with registered storage and no write bypass.
//   clk, rst  : clock, synchronous active-high reset (empties the FIFO)
//   push      : write push_dat (ignored when full unless popping too)
//   pop       : advance the read pointer (ignored when empty)
//   rd_dat    : head entry, driven from the storage registers
//   full/empty: occupancy flags; count: occupancy 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
module sif_fifo import sif_pkg::*; #(
    parameter int WIDTH = SIF_WIDTH,
    parameter int DEPTH = SIF_FIFO_DEPTH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push,
    input  logic [WIDTH-1:0]              push_dat,
    input  logic                          pop,
    output logic [WIDTH-1:0]              rd_dat,
    output logic                          full,
    output logic                          empty,
    output logic [count_width(DEPTH)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = count_width(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    // A push into a full FIFO is only taken when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign rd_dat  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            mem    <= '{default: '0};
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sif_mult_feeder.sv
// sif_mult_feeder - joins A/B operand streams into paired multiplier issues,
// limits issues with a credit counter and buffers products in a result FIFO
// so they can be re-presented as a valid/ready stream.
//   clk, rst : clock, synchronous active-high reset
//   bus      : sif_mult_feeder_if.master (operand, issue, product streams)
//   busy     : products outstanding or post-reset drain window running
//   err      : sticky protocol error (dropped product), cleared by rst
module sif_mult_feeder import sif_pkg::*; #(
    parameter int WIDTH      = SIF_WIDTH,
    parameter int FIFO_DEPTH = SIF_FIFO_DEPTH,
    parameter int MULT_LAT   = SIF_MULT_LAT
) (
    input  logic                 clk,
    input  logic                 rst,
    sif_mult_feeder_if.master    bus,
    output logic                 busy,
    output logic                 err
);

    localparam int CNT_W = count_width(FIFO_DEPTH);
    localparam int DRN_W = count_width(MULT_LAT);

    logic [CNT_W-1:0] outstanding;
    logic [CNT_W-1:0] fifo_count;
    logic [CNT_W-1:0] in_flight;
    logic [DRN_W-1:0] drain_cnt;
    logic             draining;
    logic             credit_ok;
    logic             fire;
    logic             pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic             orphan;
    logic             overflow;
    logic             push;

    assign draining  = (drain_cnt != '0);
    assign credit_ok = !rst && !draining && (outstanding < CNT_W'(FIFO_DEPTH));

    // Each ready depends on the other side's valid, so one operand is never
    // taken without its partner.
    assign bus.A_rdy = bus.B_vld & credit_ok;
    assign bus.B_rdy = bus.A_vld & credit_ok;
    assign fire      = bus.A_vld & bus.B_vld & credit_ok;

    assign bus.P_vld = !fifo_empty;
    assign pop       = bus.P_vld & bus.P_rdy;

    // Products still inside the multiplier; a product arriving when this is
    // zero has no matching issue. Products from before a reset are discarded
    // while draining.
    assign in_flight = outstanding - fifo_count;
    assign orphan    = bus.M_P_vld && !draining && (in_flight == '0);
    assign overflow  = bus.M_P_vld && !draining && fifo_full && !pop;
    assign push      = bus.M_P_vld && !draining && !orphan && !overflow;

    assign busy = (outstanding != '0) || draining;

    // Issue register: vld follows fire, data holds between issues.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.M_A_vld <= 1'b0;
            bus.M_B_vld <= 1'b0;
            bus.M_A_dat <= '0;
            bus.M_B_dat <= '0;
        end else begin
            bus.M_A_vld <= fire;
            bus.M_B_vld <= fire;
            if (fire) begin
                bus.M_A_dat <= bus.A_dat;
                bus.M_B_dat <= bus.B_dat;
            end
        end
    end

    // Credits: one per issue, returned when the product leaves downstream.
    always_ff @(posedge clk) begin
        if (rst) begin
            outstanding <= '0;
        end else begin
            case ({fire, pop})
                2'b10:   outstanding <= outstanding + CNT_W'(1);
                2'b01:   outstanding <= outstanding - CNT_W'(1);
                default: outstanding <= outstanding;
            endcase
        end
    end

    // Drain window after reset swallows products of pre-reset issues.
    always_ff @(posedge clk) begin
        if (rst) begin
            drain_cnt <= DRN_W'(MULT_LAT);
        end else if (draining) begin
            drain_cnt <= drain_cnt - DRN_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err <= 1'b0;
        end else if (orphan || overflow) begin
            err <= 1'b1;
        end
    end

    sif_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_dat (bus.M_P_dat),
        .pop      (pop),
        .rd_dat   (bus.P_dat),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

endmodule
